bip_control_unit: RTL and testbench

- Sequencing FSM for the accumulator CPU. Drives the program counter (address_bus, WrPC) and decodes 16-bit instructions into the accumulator/ALU/data-RAM control strobes.
- Sits between program memory (synchronous read, 1-cycle latency) and the PC/accumulator datapath.
- Runs INIT, then FETCH/EXEC pairs until HLT. Counts executed cycles.

---
 rtl/bip_control_unit.sv | 217 +++++++++++++++++++++
 tb/tb_bip_control_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// bip_control_unit: sequencing FSM for the accumulator CPU.
// Loads the PC with 0 at start-up and then alternates FETCH/EXEC. In EXEC the
// current instruction is decoded into accumulator, ALU and data-RAM strobes.
// The program memory has a synchronous read, so the FETCH cycle is where the
// instruction for the new PC is read out. The FSM stops on HLT.
//
// Optional build macro: BIP_ILLEGAL_TRAP_EN
//   When it is defined, an undefined opcode in EXEC halts the sequencer and
//   sets the sticky illegal_op output. When it is not defined, an undefined
//   opcode executes as a NOP and the illegal_op port does not exist.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start, all strobes low
// INIT  | one cycle, WrPC with address_bus = 0 (the PC has no reset)
// FETCH | one cycle, program memory reads the instruction at pc_addr
// EXEC  | one cycle, decoded strobes, PC advance or halt
// HALT  | stopped, only rst leaves this state

module bip_control_unit #(
    parameter int AB  = 11,
    parameter int OPW = 5,
    parameter int CW  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AB-1:0]     pc_addr,
    input  logic [OPW+AB-1:0] instr,
    output logic [AB-1:0]     address_bus,
    output logic              WrPC,
    output logic [AB-1:0]     operand,
    output logic [1:0]        SelA,
    output logic              SelB,
    output logic              Op,
    output logic              WrAcc,
    output logic              WrRam,
    output logic              RdRam,
    output logic              busy,
    output logic              halted,
    output logic [CW-1:0]     cycle_count
`ifdef BIP_ILLEGAL_TRAP_EN
    ,
    output logic              illegal_op
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_FETCH = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
    localparam logic [OPW-1:0] OP_STO  = OPW'(1);
    localparam logic [OPW-1:0] OP_LD   = OPW'(2);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(7);

    localparam logic [1:0] SELA_RAM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;

    state_t         state;
    logic [OPW-1:0] opcode;
    logic           op_defined;
    logic           trap;
    logic           exec_stop;

    assign opcode  = instr[OPW+AB-1:AB];
    assign operand = instr[AB-1:0];

    // Opcode classification: which opcodes exist, and which ones end execution.
    always_comb begin
        op_defined = (opcode <= OP_SUBI);
`ifdef BIP_ILLEGAL_TRAP_EN
        trap = !op_defined;
`else
        trap = 1'b0;
`endif
        exec_stop = (opcode == OP_HLT) || trap;
    end

    // PC control and datapath strobes. These are decoded combinationally
    // because the instruction only becomes valid during EXEC.
    always_comb begin
        address_bus = '0;
        WrPC        = 1'b0;
        SelA        = SELA_RAM;
        SelB        = 1'b0;
        Op          = 1'b0;
        WrAcc       = 1'b0;
        WrRam       = 1'b0;
        RdRam       = 1'b0;
        if (!rst) begin
            case (state)
                S_INIT: begin
                    WrPC        = 1'b1;
                    address_bus = '0;
                end
                S_EXEC: begin
                    if (exec_stop) begin
                        // Hold the PC on the halting instruction.
                        address_bus = pc_addr;
                    end else begin
                        WrPC        = 1'b1;
                        address_bus = pc_addr + AB'(1);
                        case (opcode)
                            OP_STO: begin
                                WrRam = 1'b1;
                            end
                            OP_LD: begin
                                RdRam = 1'b1;
                                SelA  = SELA_RAM;
                                WrAcc = 1'b1;
                            end
                            OP_LDI: begin
                                SelA  = SELA_IMM;
                                WrAcc = 1'b1;
                            end
                            OP_ADD: begin
                                RdRam = 1'b1;
                                SelB  = 1'b0;
                                Op    = 1'b0;
                                SelA  = SELA_ALU;
                                WrAcc = 1'b1;
                            end
                            OP_ADDI: begin
                                SelB  = 1'b1;
                                Op    = 1'b0;
                                SelA  = SELA_ALU;
                                WrAcc = 1'b1;
                            end
                            OP_SUB: begin
                                RdRam = 1'b1;
                                SelB  = 1'b0;
                                Op    = 1'b1;
                                SelA  = SELA_ALU;
                                WrAcc = 1'b1;
                            end
                            OP_SUBI: begin
                                SelB  = 1'b1;
                                Op    = 1'b1;
                                SelA  = SELA_ALU;
                                WrAcc = 1'b1;
                            end
                            default: begin
                                // Undefined opcode without the trap: the PC
                                // still advances but nothing else happens.
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sequencer state, registered status flags and the FETCH/EXEC cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            halted      <= 1'b0;
            cycle_count <= '0;
`ifdef BIP_ILLEGAL_TRAP_EN
            illegal_op  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_INIT;
                        busy  <= 1'b1;
                    end
                end
                S_INIT: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    state       <= S_EXEC;
                    cycle_count <= cycle_count + CW'(1);
                end
                S_EXEC: begin
                    cycle_count <= cycle_count + CW'(1);
                    if (exec_stop) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
`ifdef BIP_ILLEGAL_TRAP_EN
                        if (trap) begin
                            illegal_op <= 1'b1;
                        end
`endif
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit. It holds the program counter and a synchronous
// program ROM around the DUT, together with a phase-level reference model.
// Every cycle the DUT outputs are compared with that model, and a set of
// literal expectations pins the model itself.
module tb_bip_control_unit;

    localparam int AB = 11;
    localparam int CW = 32;

`ifdef BIP_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_INIT  = 1;
    localparam int P_FETCH = 2;
    localparam int P_EXEC  = 3;
    localparam int P_HALT  = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AB-1:0] pc;
    logic [15:0]   instr;
    logic [AB-1:0] address_bus;
    logic          WrPC;
    logic [AB-1:0] operand;
    logic [1:0]    SelA;
    logic          SelB, Op, WrAcc, WrRam, RdRam, busy, halted;
    logic [CW-1:0] cycle_count;
`ifdef BIP_ILLEGAL_TRAP_EN
    logic          illegal_op;
`endif

    logic [15:0]   prog [2048];
    logic          pc_ov;
    logic [AB-1:0] pc_ov_val;

    int            m_ph;
    logic [CW-1:0] m_cnt;
    logic          m_ill;

    int            n_checks;
    int            n_pass;

    bip_control_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc_addr     (pc),
        .instr       (instr),
        .address_bus (address_bus),
        .WrPC        (WrPC),
        .operand     (operand),
        .SelA        (SelA),
        .SelB        (SelB),
        .Op          (Op),
        .WrAcc       (WrAcc),
        .WrRam       (WrRam),
        .RdRam       (RdRam),
        .busy        (busy),
        .halted      (halted),
        .cycle_count (cycle_count)
`ifdef BIP_ILLEGAL_TRAP_EN
        ,
        .illegal_op  (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter (no reset, loaded on WrPC) and a 1-cycle-latency ROM.
    always @(posedge clk) begin
        if (pc_ov)
            pc <= pc_ov_val;
        else if (WrPC)
            pc <= address_bus;
        instr <= prog[pc];
    end

    // Reference model: where the sequencer is and how many FETCH/EXEC cycles it has run.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph  <= P_IDLE;
            m_cnt <= '0;
            m_ill <= 1'b0;
        end else begin
            case (m_ph)
                P_IDLE:  if (start) m_ph <= P_INIT;
                P_INIT:  m_ph <= P_FETCH;
                P_FETCH: begin
                    m_ph  <= P_EXEC;
                    m_cnt <= m_cnt + 1;
                end
                P_EXEC: begin
                    m_cnt <= m_cnt + 1;
                    if (instr[15:11] == 5'd0)
                        m_ph <= P_HALT;
                    else if (TRAP && instr[15:11] > 5'd7) begin
                        m_ph  <= P_HALT;
                        m_ill <= 1'b1;
                    end else
                        m_ph <= P_FETCH;
                end
                default: ;
            endcase
        end
    end

    // Expected {SelA, SelB, Op, WrAcc, WrRam, RdRam} for each opcode.
    function automatic logic [6:0] exp_ctrl(input logic [4:0] opc);
        case (opc)
            5'd1:    return 7'b00_0_0_0_1_0;
            5'd2:    return 7'b00_0_0_1_0_1;
            5'd3:    return 7'b01_0_0_1_0_0;
            5'd4:    return 7'b10_0_0_1_0_1;
            5'd5:    return 7'b10_1_0_1_0_0;
            5'd6:    return 7'b10_0_1_1_0_1;
            5'd7:    return 7'b10_1_1_1_0_0;
            default: return 7'b00_0_0_0_0_0;
        endcase
    endfunction

    function automatic logic [15:0] mk(input int opc, input int opd);
        return {opc[4:0], opd[10:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic compare_all();
        logic [4:0]    opc;
        logic          exec_go;
        logic [AB-1:0] nxt;
        logic [6:0]    ctrl;
        opc     = instr[15:11];
        exec_go = (m_ph == P_EXEC) && (opc != 5'd0) && !(TRAP && opc > 5'd7);
        nxt     = pc + 11'd1;
        ctrl    = (m_ph == P_EXEC) ? exp_ctrl(opc) : 7'd0;
        check("WrPC", WrPC, (m_ph == P_INIT) || exec_go);
        if (m_ph == P_INIT) check("address_bus_init", address_bus, 0);
        if (exec_go) check("address_bus_next", address_bus, nxt);
        check("strobes", {SelA, SelB, Op, WrAcc, WrRam, RdRam}, ctrl);
        check("operand", operand, instr[10:0]);
        check("busy", busy, (m_ph == P_INIT) || (m_ph == P_FETCH) || (m_ph == P_EXEC));
        check("halted", halted, m_ph == P_HALT);
        check("cycle_count", cycle_count, m_cnt);
`ifdef BIP_ILLEGAL_TRAP_EN
        check("illegal_op", illegal_op, m_ill);
`endif
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) compare_all();
    endtask

    task automatic wait_for(input int ph, input int pc_want, input int budget, input string nm);
        int n;
        n = 0;
        while (!(m_ph == ph && (pc_want < 0 || int'(pc) == pc_want)) && n < budget) begin
            step();
            n++;
        end
        check(nm, (m_ph == ph), 1);
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
        check("init_WrPC", WrPC, 1);
        check("init_address_bus", address_bus, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic load_prog_a();
        foreach (prog[i]) prog[i] = 16'h0000;
        prog[0] = mk(3, 5);
        prog[1] = mk(5, 3);
        prog[2] = mk(1, 2);
        prog[3] = mk(0, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        pc_ov     = 1'b0;
        pc_ov_val = '0;
        load_prog_a();
        #3;
        check("rst_WrPC", WrPC, 0);
        check("rst_address_bus", address_bus, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_cycle_count", cycle_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Idle without start.
        repeat (10) step();
        check("idle_cycle_count", cycle_count, 0);
        check("idle_busy", busy, 0);

        // Program A: LDI 5, ADDI 3, STO 2, HLT.
        kick();
        wait_for(P_EXEC, 0, 10, "wait_exec_ldi");
        check("ldi_SelA", SelA, 1);
        check("ldi_WrAcc", WrAcc, 1);
        wait_for(P_EXEC, 2, 10, "wait_exec_sto");
        check("sto_WrRam", WrRam, 1);
        wait_for(P_HALT, -1, 20, "wait_halt_a");
        check("a_halted", halted, 1);
        check("a_cycle_count", cycle_count, 8);

        // start pulses in HALT are ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("halt_hold", halted, 1);
        check("halt_WrPC", WrPC, 0);
        check("halt_cycle_count", cycle_count, 8);

        // Program B: LD 7, SUB 7, undefined opcode 31, ADDI 1, HLT.
        do_reset();
        foreach (prog[i]) prog[i] = 16'h0000;
        prog[0] = mk(2, 7);
        prog[1] = mk(6, 7);
        prog[2] = mk(31, 5);
        prog[3] = mk(5, 1);
        prog[4] = mk(0, 0);
        kick();
        step();
        check("fetch_strobes", {SelA, SelB, Op, WrAcc, WrRam, RdRam}, 0);
        wait_for(P_EXEC, 0, 10, "wait_exec_ld");
        check("ld_RdRam", RdRam, 1);
        check("ld_operand", operand, 7);
        check("ld_SelA", SelA, 0);
        check("ld_WrAcc", WrAcc, 1);
        wait_for(P_EXEC, 1, 10, "wait_exec_sub");
        check("sub_ctrl", {SelA, SelB, Op, WrAcc, RdRam}, 6'b10_0_1_1_1);
        wait_for(P_EXEC, 2, 10, "wait_exec_illegal");
`ifdef BIP_ILLEGAL_TRAP_EN
        check("ill_WrPC", WrPC, 0);
        step();
        check("ill_halted", halted, 1);
        check("ill_flag", illegal_op, 1);
        check("ill_cycle_count", cycle_count, 6);
`else
        check("nop_WrPC", WrPC, 1);
        check("nop_address_bus", address_bus, 3);
        wait_for(P_HALT, -1, 20, "wait_halt_b");
        check("b_cycle_count", cycle_count, 10);
`endif

        // Async reset in the middle of EXEC, then a clean restart.
        do_reset();
        load_prog_a();
        kick();
        wait_for(P_EXEC, 1, 10, "wait_exec_mid");
        #2 rst = 1'b1;
        #1;
        check("arst_WrPC", WrPC, 0);
        check("arst_WrAcc", WrAcc, 0);
        check("arst_SelA", SelA, 0);
        check("arst_busy", busy, 0);
        check("arst_cycle_count", cycle_count, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_busy", busy, 0);
        kick();
        wait_for(P_HALT, -1, 30, "wait_halt_restart");
        check("restart_cycle_count", cycle_count, 8);

        // PC wrap: steer the PC to 2047 where an ADDI sits.
        do_reset();
        load_prog_a();
        prog[2047] = mk(5, 1);
        kick();
        wait_for(P_EXEC, 0, 10, "wait_exec_pre_wrap");
        pc_ov     = 1'b1;
        pc_ov_val = 11'd2047;
        step();
        pc_ov = 1'b0;
        step();
        check("wrap_pc", pc, 2047);
        check("wrap_address_bus", address_bus, 0);
        check("wrap_WrPC", WrPC, 1);
        wait_for(P_HALT, -1, 30, "wait_halt_wrap");
        check("wrap_cycle_count", cycle_count, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
